// File: rtl/pcpi_arbiter_if.sv
// PCPI bundles: the core-side port (one lane) and the coprocessor-side port (N lanes).
// master drives valid/insn/operands; slave returns wr/rd/wait/ready.
interface pcpi_arbiter_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic [31:0] pcpi_rs3;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn,
    output pcpi_rs1, pcpi_rs2, pcpi_rs3,
    input  pcpi_wr, pcpi_rd,
    input  pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn,
    input  pcpi_rs1, pcpi_rs2, pcpi_rs3,
    output pcpi_wr, pcpi_rd,
    output pcpi_wait, pcpi_ready
  );
endinterface

interface pcpi_arbiter_cop_if #(
  parameter int N = 3
);
  logic [N-1:0]    pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [31:0]     pcpi_rs1;
  logic [31:0]     pcpi_rs2;
  logic [31:0]     pcpi_rs3;
  logic [N-1:0]    pcpi_wr;
  logic [32*N-1:0] pcpi_rd;
  logic [N-1:0]    pcpi_wait;
  logic [N-1:0]    pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn,
    output pcpi_rs1, pcpi_rs2, pcpi_rs3,
    input  pcpi_wr, pcpi_rd,
    input  pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn,
    input  pcpi_rs1, pcpi_rs2, pcpi_rs3,
    output pcpi_wr, pcpi_rd,
    output pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_arbiter.sv
// pcpi_arbiter: shares one PCPI core port among NCOP coprocessors.
// Ports: clk, reset (sync, active-high); m = core side (slave modport);
// s = coprocessor side (master modport, NCOP lanes, rd slice i = [32*i+31:32*i]);
// unclaimed/conflict/hung = one-cycle flag pulses; grant_idx = last winner.
module pcpi_arbiter #(
  parameter int NCOP          = 3,
  parameter int CLAIM_TIMEOUT = 4,
  parameter int BUSY_TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  pcpi_arbiter_if.slave      m,
  pcpi_arbiter_cop_if.master s,
  output logic               unclaimed,
  output logic               conflict,
  output logic               hung,
  output logic [2:0]         grant_idx
);

  localparam int CW = $clog2(CLAIM_TIMEOUT + 1);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLAIM_TIMEOUT);
  localparam logic [BW-1:0] BMAX = BW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    LOCKED,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]   claim_cnt;
  logic [BW-1:0]   busy_cnt;
  logic [CW-1:0]   claim_base;
  logic [CW-1:0]   claim_inc;
  logic [BW-1:0]   busy_inc;

  logic [NCOP-1:0] claims;
  logic            any_claim;
  logic            multi;
  logic [2:0]      win;

  logic            req;
  logic            offering;
  logic            claim_hit;
  logic            locked_act;
  logic            slot_act;
  logic [2:0]      sel;

  logic            sel_wait;
  logic            sel_ready;
  logic            sel_wr;
  logic [31:0]     sel_rd;
  logic [NCOP-1:0] s_valid;

  assign s.pcpi_insn = m.pcpi_insn;
  assign s.pcpi_rs1  = m.pcpi_rs1;
  assign s.pcpi_rs2  = m.pcpi_rs2;
  assign s.pcpi_rs3  = m.pcpi_rs3;

  assign req       = m.pcpi_valid;
  assign claims    = s.pcpi_wait | s.pcpi_ready;
  assign any_claim = |claims;
  // more than one bit set: clearing the lowest set bit leaves something
  assign multi     = |(claims & (claims - NCOP'(1)));

  always_comb begin
    win = '0;
    for (int i = NCOP - 1; i >= 0; i--) begin
      if (claims[i]) win = 3'(i);
    end
  end

  assign offering   = req && (state == IDLE || state == OFFER);
  assign claim_hit  = offering && any_claim;
  assign locked_act = req && (state == LOCKED);
  assign slot_act   = claim_hit || locked_act;
  // in the claim cycle the fresh winner is routed before grant_idx updates
  assign sel        = claim_hit ? win : grant_idx;

  always_comb begin
    sel_wait  = 1'b0;
    sel_ready = 1'b0;
    sel_wr    = 1'b0;
    sel_rd    = '0;
    for (int i = 0; i < NCOP; i++) begin
      if (sel == 3'(i)) begin
        sel_wait  = s.pcpi_wait[i];
        sel_ready = s.pcpi_ready[i];
        sel_wr    = s.pcpi_wr[i];
        sel_rd    = s.pcpi_rd[32*i +: 32];
      end
    end
  end

  always_comb begin
    s_valid = '0;
    if (offering) begin
      s_valid = '1;
    end else if (locked_act) begin
      for (int i = 0; i < NCOP; i++) begin
        s_valid[i] = (grant_idx == 3'(i));
      end
    end
  end

  assign s.pcpi_valid = s_valid;
  assign m.pcpi_wait  = slot_act & sel_wait;
  assign m.pcpi_ready = slot_act & sel_ready;
  assign m.pcpi_wr    = slot_act & sel_wr;
  assign m.pcpi_rd    = slot_act ? sel_rd : '0;

  // IDLE starts a fresh count, so the first offer cycle counts as 1
  assign claim_base = (state == IDLE) ? '0 : claim_cnt;
  assign claim_inc  = (claim_base == CMAX) ? CMAX
                                           : claim_base + CW'(1);
  assign busy_inc   = (busy_cnt == BMAX) ? BMAX
                                         : busy_cnt + BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      claim_cnt <= '0;
      busy_cnt  <= '0;
      unclaimed <= 1'b0;
      conflict  <= 1'b0;
      hung      <= 1'b0;
    end else begin
      unclaimed <= 1'b0;
      conflict  <= 1'b0;
      hung      <= 1'b0;
      unique case (state)
        IDLE, OFFER: begin
          if (!req) begin
            state     <= IDLE;
            claim_cnt <= '0;
          end else if (any_claim) begin
            grant_idx <= win;
            conflict  <= multi;
            claim_cnt <= '0;
            busy_cnt  <= '0;
            state     <= sel_ready ? DONE : LOCKED;
          end else if (int'(claim_inc) >= CLAIM_TIMEOUT) begin
            claim_cnt <= claim_inc;
            unclaimed <= 1'b1;
            state     <= DONE;
          end else begin
            claim_cnt <= claim_inc;
            state     <= OFFER;
          end
        end
        LOCKED: begin
          if (!req) begin
            state <= IDLE;
          end else if (sel_ready) begin
            state <= DONE;
          end else if (int'(busy_inc) >= BUSY_TIMEOUT) begin
            busy_cnt <= busy_inc;
            hung     <= 1'b1;
            state    <= DONE;
          end else begin
            busy_cnt <= busy_inc;
          end
        end
        DONE: begin
          if (!req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_arbiter.sv
// tb_pcpi_arbiter: randomized request/coprocessor timing against a
// timeline reference model, with a scoreboard monitor per cycle.
module tb_pcpi_arbiter;

  localparam int NCOP = 3;
  localparam int CT   = 4;
  localparam int BT   = 64;
  localparam int BIG  = 1 << 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       unclaimed;
  logic       conflict;
  logic       hung;
  logic [2:0] grant_idx;

  pcpi_arbiter_if mif ();
  pcpi_arbiter_cop_if #(.N(NCOP)) sif ();

  pcpi_arbiter #(
    .NCOP(NCOP),
    .CLAIM_TIMEOUT(CT),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m(mif),
    .s(sif),
    .unclaimed(unclaimed),
    .conflict(conflict),
    .hung(hung),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  // kind: 0 = result returned, 1 = unclaimed, 2 = hung
  // c = claim cycle, dc = decision cycle, k = cycle the core drops valid
  typedef struct {
    int          kind;
    int          c;
    int          dc;
    int          w;
    int          lw;
    int          k;
    bit          conf;
    logic [31:0] rd;
    bit          wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_grant = 0;
  bit   mon_en = 1'b0;

  // per-coprocessor schedule: claims at cycle d (-1 = never),
  // waits l cycles, then ready with crd/cwr
  int          d[NCOP];
  int          l[NCOP];
  logic [31:0] crd[NCOP];
  bit          cwr[NCOP];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(int k);
    exp_t e;
    int   n;
    n = 0;
    e.c = -1;
    e.k = k;
    e.w = 0;
    e.lw = 0;
    e.conf = 1'b0;
    e.rd = '0;
    e.wr = 1'b0;
    for (int i = 0; i < NCOP; i++) begin
      if (d[i] >= 0 && (e.c < 0 || d[i] < e.c)) e.c = d[i];
    end
    if (e.c < 0 || e.c >= CT) begin
      e.kind = 1;
      e.c = CT;
      e.dc = CT - 1;
    end else begin
      for (int i = NCOP - 1; i >= 0; i--) begin
        if (d[i] == e.c) begin
          e.w = i;
          n++;
        end
      end
      e.conf = (n > 1);
      e.lw = l[e.w];
      if (e.lw > BT) begin
        e.kind = 2;
        e.dc = e.c + BT;
      end else begin
        e.kind = 0;
        e.dc = e.c + e.lw;
        e.rd = crd[e.w];
        e.wr = cwr[e.w];
      end
    end
    return e;
  endfunction

  task automatic clear_cops();
    sif.pcpi_wait = '0;
    sif.pcpi_ready = '0;
    sif.pcpi_wr = '0;
    sif.pcpi_rd = '0;
  endtask

  task automatic set_none();
    for (int i = 0; i < NCOP; i++) begin
      d[i] = -1;
      l[i] = 0;
      crd[i] = $urandom;
      cwr[i] = 1'b1;
    end
  endtask

  task automatic run_txn(int k);
    exp_t e;
    int   t;
    int   te;
    int   h;
    bit   v;
    bit   rdy;
    e = model(k);
    exp_q.push_back(e);
    t = 0;
    te = -1;
    h = $urandom_range(0, 2);
    mif.pcpi_insn = $urandom;
    mif.pcpi_rs1 = $urandom;
    mif.pcpi_rs2 = $urandom;
    mif.pcpi_rs3 = $urandom;
    while (1) begin
      v = (t < k) && (te < 0 || t < te + 2 + h);
      mif.pcpi_valid = v;
      if (!v) break;
      for (int i = 0; i < NCOP; i++) begin
        rdy = d[i] >= 0 && t == d[i] + l[i];
        sif.pcpi_wait[i] = d[i] >= 0 && t >= d[i] && t < d[i] + l[i];
        sif.pcpi_ready[i] = rdy;
        sif.pcpi_wr[i] = rdy ? cwr[i] : 1'($urandom);
        sif.pcpi_rd[32*i +: 32] = rdy ? crd[i] : $urandom;
      end
      @(negedge clk);
      if (te < 0 && (mif.pcpi_ready || unclaimed || hung)) te = t;
      if (te < 0 && t > 300) begin
        checks++;
        failures++;
        $display("FAIL txn_timeout: no result after %0d cycles", t);
        te = t - 2;
        h = 0;
      end
      @(posedge clk);
      #1;
      t++;
    end
    clear_cops();
    repeat ($urandom_range(1, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor state
  bit              m_in;
  int              m_t;
  exp_t            m_e;
  logic [NCOP-1:0] m_oh;
  logic [NCOP-1:0] m_sv;
  bit              m_v;
  bit              e_wait;
  bit              e_rdy;
  bit              e_conf;
  bit              e_unc;
  bit              e_hung;
  bit              m_claimed;
  bit              m_wd;
  int              m_ceff;

  initial begin
    m_in = 1'b0;
    m_t = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!m_in && mif.pcpi_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: request with empty queue");
          end else begin
            m_e = exp_q.pop_front();
            m_in = 1'b1;
            m_t = 0;
          end
        end
        if (m_in) begin
          m_v = mif.pcpi_valid;
          m_claimed = (m_e.kind != 1) && (m_e.c < m_e.k);
          m_wd = (m_e.k <= m_e.dc);
          m_ceff = (m_e.kind == 1) ? m_e.dc : m_e.c;
          m_oh = '0;
          m_oh[m_e.w] = 1'b1;
          if (!m_v) m_sv = '0;
          else if (m_t <= m_ceff) m_sv = '1;
          else if (m_t <= m_e.dc) m_sv = m_oh;
          else m_sv = '0;
          e_wait = m_v && m_e.kind != 1 && m_t >= m_e.c &&
                   m_t <= m_e.dc && m_t < m_e.c + m_e.lw;
          e_rdy = m_v && m_e.kind == 0 && m_t == m_e.dc;
          e_conf = m_e.conf && m_claimed && m_t == m_e.c + 1;
          e_unc = m_e.kind == 1 && !m_wd && m_t == m_e.dc + 1;
          e_hung = m_e.kind == 2 && !m_wd && m_t == m_e.dc + 1;
          chk($sformatf("cycle%0d sv/wait/rdy/conf/unc/hung", m_t),
              {sif.pcpi_valid, mif.pcpi_wait, mif.pcpi_ready,
               conflict, unclaimed, hung},
              {m_sv, e_wait, e_rdy, e_conf, e_unc, e_hung});
          if (e_rdy) begin
            chk("m_rd", mif.pcpi_rd, m_e.rd);
            chk("m_wr", mif.pcpi_wr, m_e.wr);
          end
          if (!m_v) begin
            m_in = 1'b0;
            if (m_claimed) exp_grant = m_e.w;
            chk("grant_idx", grant_idx, exp_grant);
          end else begin
            m_t++;
          end
        end else begin
          chk("idle outputs",
              {sif.pcpi_valid, mif.pcpi_wait, mif.pcpi_ready,
               conflict, unclaimed, hung}, '0);
        end
      end
    end
  end

  exp_t pre;
  int   k;
  int   r;

  initial begin
    reset = 1'b1;
    mif.pcpi_valid = 1'b0;
    mif.pcpi_insn = '0;
    mif.pcpi_rs1 = '0;
    mif.pcpi_rs2 = '0;
    mif.pcpi_rs3 = '0;
    clear_cops();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant_idx", grant_idx, 0);
    chk("reset flags", {unclaimed, conflict, hung}, 0);
    chk("reset s_valid", sif.pcpi_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset outputs",
        {sif.pcpi_valid, mif.pcpi_ready, mif.pcpi_wait, grant_idx}, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // cop1 claims and answers in the same cycle
    set_none();
    d[1] = 0;
    l[1] = 0;
    crd[1] = 32'h12345678;
    run_txn(BIG);
    // cop2 waits 5 cycles then answers
    set_none();
    d[2] = 0;
    l[2] = 5;
    run_txn(BIG);
    // nobody answers
    set_none();
    run_txn(BIG);
    // cop0 and cop2 claim together
    set_none();
    d[0] = 0;
    d[2] = 0;
    l[0] = 3;
    l[2] = 3;
    run_txn(BIG);
    // answer on the last allowed busy cycle, then one beyond
    set_none();
    d[1] = 0;
    l[1] = BT;
    run_txn(BIG);
    set_none();
    d[1] = 0;
    l[1] = BT + 1;
    run_txn(BIG);
    // latest claim that still counts, then the first that does not
    set_none();
    d[0] = CT - 1;
    l[0] = 1;
    run_txn(BIG);
    set_none();
    d[2] = CT;
    run_txn(BIG);
    // core withdraws mid-wait
    set_none();
    d[1] = 0;
    l[1] = 10;
    run_txn(4);

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NCOP; i++) begin
        d[i] = ($urandom_range(0, 9) < 4) ? -1 : int'($urandom_range(0, 5));
        r = $urandom_range(0, 9);
        if (r < 8) l[i] = $urandom_range(0, 6);
        else if (r < 9) l[i] = $urandom_range(7, 20);
        else l[i] = $urandom_range(60, 68);
        crd[i] = $urandom;
        cwr[i] = 1'($urandom);
      end
      pre = model(BIG);
      k = BIG;
      if ($urandom_range(0, 6) == 0 && pre.dc >= 1) begin
        k = $urandom_range(1, pre.dc);
      end
      run_txn(k);
    end

    // reset while cop1 is locked and waiting
    mon_en = 1'b0;
    mif.pcpi_valid = 1'b1;
    sif.pcpi_wait = 3'b010;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("locked s_valid", sif.pcpi_valid, 3'b010);
    chk("locked m_wait", mif.pcpi_wait, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mif.pcpi_valid = 1'b0;
    @(negedge clk);
    chk("after reset s_valid", sif.pcpi_valid, 0);
    chk("after reset m_wait", mif.pcpi_wait, 0);
    chk("after reset grant_idx", grant_idx, 0);
    @(posedge clk);
    #1;
    clear_cops();
    exp_grant = 0;
    mon_en = 1'b1;
    set_none();
    d[0] = 0;
    l[0] = 2;
    run_txn(BIG);

    repeat (3) @(posedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
